spi_flash_responder: RTL
========================

// Module: spi_flash_responder
// PURPOSE
//  SPI mode-0 target that emulates a serial flash for the spi_flash read master. Decodes READ (0x03)
//  and FAST_READ (0x0B), streams bytes MSB-first from an internal byte RAM with address auto-increment.
//  Oversamples SPI pins in the CLK domain; used in simulation benches and as a loopback flash stand-in.
// PARAMETERS
//  ADDR_BITS  12  byte-address width of internal store (2^ADDR_BITS bytes)
//  INIT_FILE  ""  optional $readmemh byte image; "" = contents zero
// PORTS
//  CLK        in   1          system clock
//  reset      in   1          synchronous, active-high reset; clock CLK
//  spi_clk    in   1          SPI clock from master, async to CLK, idle low
//  spi_cs_n   in   1          chip select, active low, async
//  spi_mosi   in   1          master-to-target data, async
//  spi_miso   out  1          target-to-master data
//  load_we    in   1          write one 32-bit word into store (CLK domain)
//  load_addr  in   ADDR_BITS-2 word address for load
//  load_data  in   32         word data, little-endian: byte 4*a+i = load_data[8i+7:8i]
//  busy       out  1          1 while a transaction is in progress (state != IDLE)
//  cmd_err    out  1          one-CLK pulse when an unsupported opcode completes
// BEHAVIOUR
//  - Sync: spi_clk, spi_cs_n, spi_mosi each through 2 flops; edges detected on synced spi_clk
//    (rise = sample, fall = shift). spi_clk period >= 8 CLK, half-period >= 4 CLK required.
//  - Reset: state=IDLE, spi_miso=0, busy=0, cmd_err=0, bit counter=0; store contents NOT cleared.
//  - Synced cs_n high (any state) -> IDLE next CLK, spi_miso=0; partial bytes discarded.
//  - States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
//    IDLE:  cs_n falls -> CMD, bit cnt=0. If cs_n already low when reset deasserts -> IGNORE.
//    CMD:   shift mosi on 8 rises. 0x03 -> ADDR; 0x0B -> ADDR (dummy flag set); other -> IGNORE,
//           cmd_err pulses the CLK after the 8th rise.
//    ADDR:  shift 24 bits MSB-first; store addr = low ADDR_BITS bits (upper bits ignored).
//           After 24th rise: -> DUMMY if flag else DATA; issue RAM read of byte[addr].
//    DUMMY: count 8 rises, mosi ignored; issue RAM read at entry to DATA.
//    DATA:  on each spi_clk fall drive next bit, MSB first; first fall after final addr/dummy rise
//           drives bit7 of byte[addr]. After bit0 is driven, addr <= addr+1 (mod 2^ADDR_BITS)
//           and prefetch next byte, ready before next fall. Stream continues until cs_n rises.
//    IGNORE: spi_miso=0, no action until cs_n high.
//  - spi_miso changes only in CLK cycle following a detected fall (<= 3 CLK after pin edge);
//    stable at every rise. spi_miso=0 outside DATA.
//  - RAM: 1 write port (load), 1 read port, 1-CLK synchronous read. load_we during DATA is
//    allowed; a byte already prefetched keeps its old value, later bytes see new data.
//  - Wrap: addr 2^ADDR_BITS-1 followed by byte 0. Address bits >= ADDR_BITS alias.
//  - reset asserted mid-transaction: outputs to reset values; bus ignored until cs_n deasserts.
//  - mosi activity in DATA is ignored; spi_clk rises with cs_n high are ignored.
// TESTING
//  1 load words 0x03020100,0x07060504 @0,1; cs low, send 03 000001, clock 32 bits -> MISO
//    bytes 01 02 03 04 (MSB-first), busy=1; cs high -> busy=0 within 3 CLK, miso=0.
//  2 send 0B 000004 + dummy 0xA5, clock 16 bits -> 04 05; cmd_err stays 0.
//  3 ADDR_BITS=12: store[0xFFF]=0xAA, store[0]=0x55; READ at 0x000FFF and at 0x801FFF ->
//    both return AA 55 (wrap + upper-bit aliasing).
//  4 send opcode 0x9F -> cmd_err single-CLK pulse, miso=0 for 32 further clocks; next READ at 0 OK.
//  5 assert reset after 4 data bits of READ, keep cs low, release, keep clocking -> miso=0,
//    state IGNORE; cs high then READ 0 -> correct byte 00.
//  6 abort after 12 address bits (cs high), new READ 000002 -> 02 03; sweep spi_clk period
//    8..20 CLK with random phase -> no bit errors.

Source files
------------

// File: rtl/spi_flash_responder_if.sv
// Pin bundle for the SPI flash responder: SPI pins, CLK-domain load port and status.
// The master modport is the bench or host side; the slave modport is the responder.
interface spi_flash_responder_if #(
  parameter int ADDR_BITS = 12
);
  logic                 spi_clk;
  logic                 spi_cs_n;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 load_we;
  logic [ADDR_BITS-3:0] load_addr;
  logic [31:0]          load_data;
  logic                 busy;
  logic                 cmd_err;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi, load_we, load_addr, load_data,
    input  spi_miso, busy, cmd_err
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi, load_we, load_addr, load_data,
    output spi_miso, busy, cmd_err
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash stand-in: READ (0x03) / FAST_READ (0x0B) streamed MSB-first
// from an internal byte store, with the SPI pins oversampled in the CLK domain.
module spi_flash_responder #(
  parameter int ADDR_BITS = 12
) (
  input  logic                  CLK,
  input  logic                  reset,
  spi_flash_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_e;

  localparam int         WORDS   = 2 ** (ADDR_BITS - 2);
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value; these synchronisers also carry no reset, so a chip select already
  // low when reset releases reads as "low", never as a fresh falling edge.
  always_ff @(posedge CLK) begin
    sclk_sync_q <= {sclk_sync_q[0], bus.spi_clk};
    cs_sync_q   <= {cs_sync_q[0],   bus.spi_cs_n};
    mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
    sclk_prev_q <= sclk_sync_q[1];
    cs_prev_q   <= cs_sync_q[1];
  end

  logic sclk_rise, sclk_fall, cs_n_s, cs_fell, mosi_s;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_n_s    = cs_sync_q[1];
  assign cs_fell   = ~cs_sync_q[1] & cs_prev_q;
  assign mosi_s    = mosi_sync_q[1];

  // ---------------------------------------------------------------------------
  // Transaction state
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-2:0]   shift_q, shift_d;
  logic [ADDR_BITS-1:0]   shift_next;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   fast_q, fast_d;
  logic                   miso_q, miso_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   rd_valid_q;
  logic                   rd_en;

  // Byte store: word-wide write port, registered word read plus lane select.
  logic [31:0] mem_q [WORDS];
  logic [31:0] rd_word_q;
  logic [1:0]  rd_lane_q;
  logic [7:0]  rd_byte;

  // NOTE: the store has no reset -- its contents must survive reset, and a reset
  // would also prevent the array from mapping onto a RAM macro.
  always_ff @(posedge CLK) begin
    if (bus.load_we) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
    if (rd_en) begin
      rd_word_q <= mem_q[addr_d[ADDR_BITS-1:2]];
      rd_lane_q <= addr_d[1:0];
    end
  end

  assign rd_byte = rd_word_q[{rd_lane_q, 3'b000} +: 8];

  // Only the low ADDR_BITS of the 24-bit address are kept, which gives the
  // upper-bit aliasing for free; the low 8 bits double as the opcode.
  assign shift_next = {shift_q, mosi_s};

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    fast_d    = fast_q;
    miso_d    = miso_q;
    cmd_err_d = 1'b0;
    rd_en     = 1'b0;
    tx_byte_d = rd_valid_q ? rd_byte : tx_byte_q;

    if (cs_n_s) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d   = 5'd0;
          fast_d  = 1'b0;
          state_d = cs_fell ? S_CMD : S_IGNORE;
        end

        S_CMD: begin
          if (sclk_rise) begin
            shift_d = shift_next[ADDR_BITS-2:0];
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = 5'd0;
              if (shift_next[7:0] == OP_READ) begin
                state_d = S_ADDR;
                fast_d  = 1'b0;
              end else if (shift_next[7:0] == OP_FAST) begin
                state_d = S_ADDR;
                fast_d  = 1'b1;
              end else begin
                state_d   = S_IGNORE;
                cmd_err_d = 1'b1;
              end
            end
          end
        end

        S_ADDR: begin
          if (sclk_rise) begin
            shift_d = shift_next[ADDR_BITS-2:0];
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d  = 5'd0;
              addr_d = shift_next;
              if (fast_q) begin
                state_d = S_DUMMY;
              end else begin
                state_d = S_DATA;
                rd_en   = 1'b1;
              end
            end
          end
        end

        S_DUMMY: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d   = 5'd0;
              state_d = S_DATA;
              rd_en   = 1'b1;
            end
          end
        end

        S_DATA: begin
          // Bits go out on falls; after bit 0 the next byte is fetched, which lands
          // in tx_byte two CLKs later, well before the following fall.
          if (sclk_fall) begin
            miso_d = tx_byte_q[3'd7 - cnt_q[2:0]];
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q[2:0] == 3'd7) begin
              cnt_d  = 5'd0;
              addr_d = addr_q + ADDR_BITS'(1);
              rd_en  = 1'b1;
            end
          end
        end

        S_IGNORE: begin
          state_d = S_IGNORE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_d != S_DATA) begin
      miso_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      shift_q    <= '0;
      addr_q     <= '0;
      fast_q     <= 1'b0;
      miso_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      fast_q     <= fast_d;
      miso_q     <= miso_d;
      cmd_err_q  <= cmd_err_d;
      tx_byte_q  <= tx_byte_d;
      rd_valid_q <= rd_en;
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.cmd_err  = cmd_err_q;

endmodule
